// File: rtl/bram_stream_reader_pkg.sv
// Shared constants and types for the BRAM port-B stream reader.
// Read latency follows the BRAM_OUTREG_EN macro (primitive output register on/off).
package bram_stream_reader_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

`ifdef BRAM_OUTREG_EN
  localparam int BRAM_RD_LAT = 2;
`else
  localparam int BRAM_RD_LAT = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bram_stream_reader_sync_fifo.sv
// Small synchronous FIFO holding {last, data} beats between the BRAM and the stream port.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty flag qualifies every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a contiguous run of words from BRAM port B and streams them out with a last marker.
// Define BRAM_OUTREG_EN for the 2-cycle (output-registered) BRAM read latency.
module bram_stream_reader #(
  parameter int ADDR_W     = bram_stream_reader_pkg::ADDR_W,
  parameter int DATA_W     = bram_stream_reader_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   BRAM_PORTB_addr,
  output logic                BRAM_PORTB_en,
  output logic [3:0]          BRAM_PORTB_we,
  output logic [DATA_W-1:0]   BRAM_PORTB_din,
  output logic                BRAM_PORTB_rst,
  input  logic [DATA_W-1:0]   BRAM_PORTB_dout,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
);

  import bram_stream_reader_pkg::*;

  localparam int L     = BRAM_RD_LAT;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                done_q, done_d;
  logic [L-1:0]        sr_valid_q, sr_valid_d;
  logic [L-1:0]        sr_last_q, sr_last_d;

  logic                issue;
  logic                final_issue;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    outstanding;
  logic                beat;

  logic                fifo_push;
  logic                fifo_pop;
  logic [DATA_W:0]     fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;

  // Credit: words in the FIFO plus reads still in the BRAM pipeline never exceed FIFO_DEPTH.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + CNT_W'(sr_valid_q[i]);
    outstanding = fifo_count + inflight;
    issue       = (state_q == ST_RUN) && (remaining_q != '0) &&
                  (outstanding < CNT_W'(FIFO_DEPTH));
    final_issue = issue && (remaining_q == (ADDR_W+1)'(1));
    beat        = m_tvalid && m_tready;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          if (length != '0) state_d = ST_RUN;
          else              done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (final_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat && m_tlast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag pipeline mirrors the BRAM read latency; a tag leaving the last stage marks valid dout.
  always_comb begin
    sr_valid_d    = '0;
    sr_last_d     = '0;
    sr_valid_d[0] = issue;
    sr_last_d[0]  = final_issue;
    for (int i = 1; i < L; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_last_d[i]  = sr_last_q[i-1];
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      sr_valid_q  <= '0;
      sr_last_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      sr_valid_q  <= sr_valid_d;
      sr_last_q   <= sr_last_d;
    end
  end

  assign fifo_push = sr_valid_q[L-1] && !fifo_full;
  assign fifo_pop  = beat;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .push  (fifo_push),
    .din   ({sr_last_q[L-1], BRAM_PORTB_dout}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign m_tlast  = !fifo_empty && fifo_dout[DATA_W];

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign BRAM_PORTB_addr = addr_q;
  assign BRAM_PORTB_en   = issue;
  assign BRAM_PORTB_we   = '0;
  assign BRAM_PORTB_din  = '0;
  assign BRAM_PORTB_rst  = 1'b0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: behavioural BRAM plus per-run observation, compared to expected streams.
module tb_bram_stream_reader;

`ifdef BRAM_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done;
  logic [9:0]  bram_addr;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_din;
  logic        bram_rst;
  logic [31:0] bram_dout;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .BRAM_PORTB_addr (bram_addr),
    .BRAM_PORTB_en   (bram_en),
    .BRAM_PORTB_we   (bram_we),
    .BRAM_PORTB_din  (bram_din),
    .BRAM_PORTB_rst  (bram_rst),
    .BRAM_PORTB_dout (bram_dout),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast)
  );

  // Behavioural BRAM port B with configurable read latency.
  logic [31:0] mem [1024];
  logic [31:0] rd_stage;
  always @(posedge clk) if (bram_en) rd_stage <= mem[bram_addr];
`ifdef BRAM_OUTREG_EN
  always @(posedge clk) bram_dout <= rd_stage;
`else
  assign bram_dout = rd_stage;
`endif

  int checks = 0;
  int errors = 0;

  // Observations of one run, filled by run().
  logic [9:0]  iss_q[$];
  int          en_cyc_q[$];
  logic [31:0] dat_q[$];
  bit          lst_q[$];
  int          first_valid, done_cyc, done_cnt, last_beat_cyc;
  bit          over_f, stab_f, busy_f, timeout_f, tied_f;

  // mode: 0 ready high, 1 ready random 50%, 2 ready low until cycle 10 then high.
  task automatic run(input logic [9:0] b, input logic [10:0] n, input int mode,
                     input int extra_cyc, input logic [9:0] xb, input logic [10:0] xn);
    int acc, post;
    bit seen_done, pv, pr, pl, exp_busy;
    logic [31:0] pd;
    iss_q.delete(); en_cyc_q.delete(); dat_q.delete(); lst_q.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; last_beat_cyc = -1;
    over_f = 0; stab_f = 0; busy_f = 0; timeout_f = 0; tied_f = 0;
    acc = 0; post = 0; seen_done = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n;
    m_tready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        seen_done = 1;
      end
      exp_busy = (cyc > 0) && (n != 0) && !seen_done;
      if (busy !== exp_busy) busy_f = 1;
      if (bram_we !== 4'h0 || bram_din !== 32'h0 || bram_rst !== 1'b0) tied_f = 1;
      if (bram_en) begin
        iss_q.push_back(bram_addr);
        en_cyc_q.push_back(cyc);
      end
      if (int'(iss_q.size()) - acc > DEPTH) over_f = 1;
      if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stab_f = 1;
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (m_tvalid && m_tready) begin
        dat_q.push_back(m_tdata);
        lst_q.push_back(m_tlast);
        acc++;
        if (m_tlast) last_beat_cyc = cyc;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      if (seen_done) post++;
      if (post > 4) break;
      @(posedge clk); #1;
      start     = (cyc + 1 == extra_cyc);
      base_addr = start ? xb : 10'($urandom);
      length    = start ? xn : 11'($urandom);
      case (mode)
        1:       m_tready = 1'($urandom_range(0, 1));
        2:       m_tready = (cyc + 1 >= 10);
        default: m_tready = 1'b1;
      endcase
    end
    start = 1'b0;
    m_tready = 1'b1;
    timeout_f = !seen_done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, bram_en, bram_addr, m_tvalid, m_tlast, m_tdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%h tvalid=%b tlast=%b tdata=%h, all required 0",
               busy, done, bram_en, bram_addr, m_tvalid, m_tlast, m_tdata);
    end
    #11 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bram_en, m_tvalid} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b en=%b tvalid=%b, required 0", busy, done, bram_en, m_tvalid);
    end
  endtask

  task automatic test_basic();
    run(10'h010, 11'd4, 0, -1, '0, '0);
    checks++;
    if (timeout_f) begin errors++; $display("FAIL basic_timeout: no done seen, required done"); end
    checks++;
    if (iss_q.size() != 4) begin errors++; $display("FAIL basic_reads: got %0d reads, required 4", iss_q.size()); end
    for (int k = 0; k < iss_q.size() && k < 4; k++) begin
      checks++;
      if (iss_q[k] !== 10'(16 + k) || en_cyc_q[k] != k + 1) begin
        errors++;
        $display("FAIL basic_read%0d: addr=%h cycle=%0d, required addr=%h cycle=%0d",
                 k, iss_q[k], en_cyc_q[k], 10'(16 + k), k + 1);
      end
    end
    checks++;
    if (dat_q.size() != 4) begin errors++; $display("FAIL basic_beats: got %0d, required 4", dat_q.size()); end
    for (int k = 0; k < dat_q.size(); k++) begin
      checks++;
      if (dat_q[k] !== mem[10'(16 + k)] || lst_q[k] !== (k == 3)) begin
        errors++;
        $display("FAIL basic_beat%0d: data=%h last=%b, required data=%h last=%b",
                 k, dat_q[k], lst_q[k], mem[10'(16 + k)], (k == 3));
      end
    end
    checks++;
    if (first_valid != 2 + L || last_beat_cyc != 5 + L || done_cyc != 6 + L || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_timing: first_valid=%0d tlast=%0d done=%0d ndone=%0d, required %0d %0d %0d 1",
               first_valid, last_beat_cyc, done_cyc, done_cnt, 2 + L, 5 + L, 6 + L);
    end
    checks++;
    if (busy_f || stab_f || tied_f) begin
      errors++;
      $display("FAIL basic_flags: busy_bad=%b stable_bad=%b tied_bad=%b, required 0 0 0", busy_f, stab_f, tied_f);
    end
  endtask

  task automatic test_wrap();
    run(10'h3FE, 11'd4, 0, -1, '0, '0);
    checks++;
    if (iss_q.size() != 4 || timeout_f) begin
      errors++;
      $display("FAIL wrap_reads: got %0d reads timeout=%b, required 4 reads", iss_q.size(), timeout_f);
    end
    for (int k = 0; k < iss_q.size() && k < 4; k++) begin
      checks++;
      if (iss_q[k] !== 10'(10'h3FE + k) || dat_q.size() <= k || dat_q[k] !== mem[10'(10'h3FE + k)]) begin
        errors++;
        $display("FAIL wrap_word%0d: addr=%h, required addr=%h with matching data", k, iss_q[k], 10'(10'h3FE + k));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      logic [9:0] b;
      b = 10'($urandom);
      run(b, 11'd16, (r == 0) ? 2 : 1, -1, '0, '0);
      checks++;
      if (dat_q.size() != 16 || iss_q.size() != 16 || timeout_f) begin
        errors++;
        $display("FAIL bp%0d_count: beats=%0d reads=%0d timeout=%b, required 16 16 0", r, dat_q.size(), iss_q.size(), timeout_f);
      end
      for (int k = 0; k < dat_q.size(); k++) begin
        checks++;
        if (dat_q[k] !== mem[10'(b + k)] || lst_q[k] !== (k == 15)) begin
          errors++;
          $display("FAIL bp%0d_beat%0d: data=%h last=%b, required data=%h last=%b",
                   r, k, dat_q[k], lst_q[k], mem[10'(b + k)], (k == 15));
        end
      end
      checks++;
      if (over_f || stab_f || busy_f || done_cyc != last_beat_cyc + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL bp%0d_rules: over=%b unstable=%b busy_bad=%b done=%0d tlast=%0d ndone=%0d, required done=tlast+1 once",
                 r, over_f, stab_f, busy_f, done_cyc, last_beat_cyc, done_cnt);
      end
      if (r == 0 && en_cyc_q.size() > 4) begin
        checks++;
        if (en_cyc_q[3] != 4 || en_cyc_q[4] != 11) begin
          errors++;
          $display("FAIL bp_stall_resume: read4 at %0d read5 at %0d, required 4 and 11", en_cyc_q[3], en_cyc_q[4]);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    run(10'h155, 11'd0, 0, -1, '0, '0);
    checks++;
    if (iss_q.size() != 0 || dat_q.size() != 0 || done_cyc != 1 || done_cnt != 1 || busy_f) begin
      errors++;
      $display("FAIL zero_length: reads=%0d beats=%0d done=%0d ndone=%0d busy_bad=%b, required 0 0 1 1 0",
               iss_q.size(), dat_q.size(), done_cyc, done_cnt, busy_f);
    end
  endtask

  task automatic test_start_while_busy();
    run(10'h0A0, 11'd8, 0, 3, 10'h200, 11'd7);
    checks++;
    if (dat_q.size() != 8 || iss_q.size() != 8 || done_cnt != 1 || timeout_f) begin
      errors++;
      $display("FAIL restart_count: beats=%0d reads=%0d ndone=%0d, required 8 8 1", dat_q.size(), iss_q.size(), done_cnt);
    end
    for (int k = 0; k < dat_q.size() && k < iss_q.size(); k++) begin
      checks++;
      if (iss_q[k] !== 10'(10'h0A0 + k) || dat_q[k] !== mem[10'(10'h0A0 + k)] || lst_q[k] !== (k == 7)) begin
        errors++;
        $display("FAIL restart_word%0d: addr=%h data=%h last=%b, required addr=%h data=%h",
                 k, iss_q[k], dat_q[k], lst_q[k], 10'(10'h0A0 + k), mem[10'(10'h0A0 + k)]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit stale;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h2A0; length = 11'd20; m_tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bram_en, bram_addr, m_tvalid, m_tlast, m_tdata} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy=%b en=%b addr=%h tvalid=%b tdata=%h, required all 0",
               busy, bram_en, bram_addr, m_tvalid, m_tdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; m_tready = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_tvalid || busy || bram_en) stale = 1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL midrun_stale: activity after reset, required none"); end
    run(10'h100, 11'd2, 0, -1, '0, '0);
    checks++;
    if (dat_q.size() != 2 || iss_q.size() != 2 || timeout_f) begin
      errors++;
      $display("FAIL after_reset_count: beats=%0d reads=%0d, required 2 2", dat_q.size(), iss_q.size());
    end else begin
      checks++;
      if (iss_q[0] !== 10'h100 || iss_q[1] !== 10'h101 || dat_q[0] !== mem[10'h100] ||
          dat_q[1] !== mem[10'h101] || lst_q[0] !== 1'b0 || lst_q[1] !== 1'b1) begin
        errors++;
        $display("FAIL after_reset_data: addrs=%h,%h data=%h,%h, required 100,101 data=%h,%h",
                 iss_q[0], iss_q[1], dat_q[0], dat_q[1], mem[10'h100], mem[10'h101]);
      end
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 5; r++) begin
      logic [9:0] b;
      int n, bad;
      b = 10'($urandom);
      n = $urandom_range(1, 40);
      run(b, 11'(n), 1, -1, '0, '0);
      bad = 0;
      if (dat_q.size() != n || iss_q.size() != n) bad = -1;
      else
        for (int k = 0; k < n; k++)
          if (iss_q[k] !== 10'(b + k) || dat_q[k] !== mem[10'(b + k)] || lst_q[k] !== (k == n - 1)) bad++;
      checks++;
      if (bad != 0 || timeout_f || over_f || stab_f || busy_f || done_cyc != last_beat_cyc + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d base=%h len=%0d: bad_words=%0d beats=%0d timeout=%b over=%b unstable=%b done=%0d tlast=%0d, required clean run",
                 r, b, n, bad, dat_q.size(), timeout_f, over_f, stab_f, done_cyc, last_beat_cyc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_run();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
